// File: rtl/cache_mem_arbiter.sv
// Two-master (dcache m0, icache m1) arbiter onto a single AXI-like memory port.
// Define ARB_RR_EN for round-robin arbitration; the default build uses fixed priority (m0 over m1).
module cache_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // dcache (read/write)
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_done,
  // icache (read-only)
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_done,
  // memory side
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_arvalid,
  input  logic              mem_arready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              mem_rready,
  output logic              mem_awvalid,
  input  logic              mem_awready,
  output logic              mem_wvalid,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_wready,
  input  logic              mem_bvalid,
  output logic              mem_bready
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_ADDR = 3'd1;
  localparam logic [2:0] S_RD_DATA = 3'd2;
  localparam logic [2:0] S_WR_REQ  = 3'd3;
  localparam logic [2:0] S_WR_RESP = 3'd4;

  logic [2:0]        r_state;
  logic              r_id;          // 0 = m0 owns the bus, 1 = m1
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_m0_rdata;
  logic [DATA_W-1:0] r_m1_rdata;
  logic              r_m0_done;
  logic              r_m1_done;
  logic              r_arvalid;
  logic              r_rready;
  logic              r_awvalid;
  logic              r_wvalid;
  logic              r_bready;
`ifdef ARB_RR_EN
  logic              r_last;        // id granted most recently
`endif

  logic w_req0;
  logic w_req1;
  logic w_any;
  logic w_grant;
  logic w_is_write;

  // A requester whose done is high this cycle is still holding req from the
  // finished transaction, so it must not be re-granted.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_req0  = m0_req && !r_m0_done;
    w_req1  = m1_req && !r_m1_done;
    w_any   = w_req0 || w_req1;
    w_grant = 1'b0;
`ifdef ARB_RR_EN
    if (w_req0 && w_req1) w_grant = ~r_last;
    else                  w_grant = w_req1;
`else
    w_grant = !w_req0;
`endif
    w_is_write = !w_grant && m0_we;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_id        <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_m0_rdata  <= '0;
      r_m1_rdata  <= '0;
      r_m0_done   <= 1'b0;
      r_m1_done   <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
`ifdef ARB_RR_EN
      r_last      <= 1'b1;
`endif
    end else begin
      r_m0_done <= 1'b0;
      r_m1_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_id       <= w_grant;
            r_mem_addr <= w_grant ? m1_addr : m0_addr;
`ifdef ARB_RR_EN
            r_last     <= w_grant;
`endif
            if (w_is_write) begin
              r_mem_wdata <= m0_wdata;
              r_awvalid   <= 1'b1;
              r_wvalid    <= 1'b1;
              r_state     <= S_WR_REQ;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= S_RD_ADDR;
            end
          end
        end
        S_RD_ADDR: begin
          if (mem_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (mem_rvalid) begin
            r_rready <= 1'b0;
            if (r_id) begin
              r_m1_rdata <= mem_rdata;
              r_m1_done  <= 1'b1;
            end else begin
              r_m0_rdata <= mem_rdata;
              r_m0_done  <= 1'b1;
            end
            r_state <= S_IDLE;
          end
        end
        S_WR_REQ: begin
          // Address and data channels complete independently; move on once
          // both valids have dropped.
          if (r_awvalid && mem_awready) r_awvalid <= 1'b0;
          if (r_wvalid && mem_wready)   r_wvalid  <= 1'b0;
          if (!r_awvalid && !r_wvalid) begin
            r_bready <= 1'b1;
            r_state  <= S_WR_RESP;
          end
        end
        S_WR_RESP: begin
          if (mem_bvalid) begin
            r_bready  <= 1'b0;
            r_m0_done <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign m0_rdata    = r_m0_rdata;
  assign m0_done     = r_m0_done;
  assign m1_rdata    = r_m1_rdata;
  assign m1_done     = r_m1_done;
  assign mem_addr    = r_mem_addr;
  assign mem_arvalid = r_arvalid;
  assign mem_rready  = r_rready;
  assign mem_awvalid = r_awvalid;
  assign mem_wvalid  = r_wvalid;
  assign mem_wdata   = r_mem_wdata;
  assign mem_bready  = r_bready;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter; honours ARB_RR_EN when choosing arbitration expectations.
module tb_cache_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m0_done, m1_req, m1_done;
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_rdata;
  logic [31:0] mem_addr, mem_rdata, mem_wdata;
  logic        mem_arvalid, mem_arready, mem_rvalid, mem_rready;
  logic        mem_awvalid, mem_awready, mem_wvalid, mem_wready;
  logic        mem_bvalid, mem_bready;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cache_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_done(m0_done),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_rdata(m1_rdata), .m1_done(m1_done),
    .mem_addr(mem_addr),
    .mem_arvalid(mem_arvalid), .mem_arready(mem_arready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rready(mem_rready),
    .mem_awvalid(mem_awvalid), .mem_awready(mem_awready),
    .mem_wvalid(mem_wvalid), .mem_wdata(mem_wdata), .mem_wready(mem_wready),
    .mem_bvalid(mem_bvalid), .mem_bready(mem_bready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_m1_first;
    rst = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_addr = '0;
    mem_arready = 0; mem_rvalid = 0; mem_rdata = '0;
    mem_awready = 0; mem_wready = 0; mem_bvalid = 0;

    // Reset state
    step(); step();
    check("rst_valids", {mem_arvalid, mem_rready, mem_awvalid, mem_wvalid, mem_bready}, 5'b0);
    check("rst_dones", {m0_done, m1_done}, 2'b0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_data", {mem_wdata, m0_rdata}, 64'h0);
    check("rst_m1_rdata", m1_rdata, 32'h0);
    rst = 1'b0;

    // m1 read, zero-wait memory
    m1_req = 1; m1_addr = 32'h100;
    mem_arready = 1; mem_rvalid = 1; mem_rdata = 32'hCAFE0001;
    step();
    check("m1rd_arvalid", mem_arvalid, 1'b1);
    check("m1rd_addr", mem_addr, 32'h100);
    check("m1rd_done_c1", m1_done, 1'b0);
    step();
    check("m1rd_rready", {mem_arvalid, mem_rready}, 2'b01);
    check("m1rd_done_c2", m1_done, 1'b0);
    step();
    check("m1rd_done_c3", {m1_done, m0_done}, 2'b10);
    check("m1rd_rdata", m1_rdata, 32'hCAFE0001);
    step();
    // req still high during the done cycle must not be re-granted
    check("m1rd_no_regrant", {mem_arvalid, m1_done}, 2'b00);
    m1_req = 0; mem_arready = 0; mem_rvalid = 0;

    // m0 write: awready first, wready two cycles later
    m0_req = 1; m0_we = 1; m0_addr = 32'h40; m0_wdata = 32'hDEAD;
    mem_awready = 1;
    step();
    check("wr_valids", {mem_awvalid, mem_wvalid}, 2'b11);
    check("wr_addr", mem_addr, 32'h40);
    check("wr_wdata", mem_wdata, 32'hDEAD);
    step();
    check("wr_aw_dropped", {mem_awvalid, mem_wvalid}, 2'b01);
    mem_awready = 0;
    step();
    check("wr_w_held", {mem_wvalid, mem_bready}, 2'b10);
    mem_wready = 1;
    step();
    check("wr_w_dropped", {mem_awvalid, mem_wvalid, mem_bready}, 3'b000);
    mem_wready = 0;
    step();
    check("wr_bready", mem_bready, 1'b1);
    mem_bvalid = 1;
    step();
    check("wr_done", {m0_done, m1_done, mem_bready}, 3'b100);
    check("wr_m0_rdata_kept", m0_rdata, 32'h0);
    m0_req = 0; m0_we = 0; mem_bvalid = 0;
    step();
    check("wr_done_pulse", m0_done, 1'b0);

    // m0 read with arready stalled for 5 cycles
    m0_req = 1; m0_addr = 32'h80;
    step();
    for (int i = 0; i < 5; i++) begin
      check("stall_arvalid", mem_arvalid, 1'b1);
      check("stall_addr", mem_addr, 32'h80);
      check("stall_no_done", {m0_done, m1_done}, 2'b00);
      step();
    end
    mem_arready = 1;
    step();
    check("stall_rready", {mem_arvalid, mem_rready}, 2'b01);
    mem_arready = 0; mem_rvalid = 1; mem_rdata = 32'h12345678;
    step();
    check("stall_done", m0_done, 1'b1);
    check("stall_m0_rdata", m0_rdata, 32'h12345678);
    check("stall_m1_rdata_kept", m1_rdata, 32'hCAFE0001);
    m0_req = 0; mem_rvalid = 0;
    step();

    // Reset while waiting for rvalid
    m1_req = 1; m1_addr = 32'h200; mem_arready = 1;
    step();
    step();
    check("abort_in_rd_data", mem_rready, 1'b1);
    mem_arready = 0;
    #2 rst = 1;
    #1;
    check("abort_valids", {mem_arvalid, mem_rready, mem_awvalid, mem_wvalid, mem_bready}, 5'b0);
    check("abort_addr", mem_addr, 32'h0);
    check("abort_rdata", {m0_rdata, m1_rdata}, 64'h0);
    mem_rvalid = 1; mem_rdata = 32'hBAD;
    step();
    check("abort_no_done", {m0_done, m1_done}, 2'b00);
    rst = 0; m1_addr = 32'h300; mem_arready = 1; mem_rdata = 32'hBEEF0003;
    step();
    check("post_rst_addr", {mem_arvalid, mem_addr}, {1'b1, 32'h300});
    step();
    step();
    check("post_rst_done", m1_done, 1'b1);
    check("post_rst_rdata", m1_rdata, 32'hBEEF0003);
    m1_req = 0;
    step();

    // Both masters requesting continuously: grants alternate m0, m1, m0, m1
    m0_req = 1; m1_req = 1; m0_addr = 32'h10; m1_addr = 32'h20;
    for (int k = 0; k < 4; k++) begin
      mem_rdata = 32'hA0000000 + k;
      step(); step(); step();
      check("alt_done", {m0_done, m1_done}, (k % 2 == 0) ? 2'b10 : 2'b01);
      if (k % 2 == 0) check("alt_m0_rdata", m0_rdata, 32'hA0000000 + k);
      else            check("alt_m1_rdata", m1_rdata, 32'hA0000000 + k);
    end
    m0_req = 0; m1_req = 0;
    step();
    check("alt_idle", mem_arvalid, 1'b0);

    // m0 alone, then a simultaneous request: fixed priority picks m0 again,
    // round-robin picks m1 because m0 was granted last.
    m0_req = 1; mem_rdata = 32'h55;
    step(); step(); step();
    check("solo_m0_done", m0_done, 1'b1);
    m0_req = 0;
    step();
`ifdef ARB_RR_EN
    exp_m1_first = 1'b1;
`else
    exp_m1_first = 1'b0;
`endif
    m0_req = 1; m1_req = 1; mem_rdata = 32'h66;
    step();
    check("arb_addr", mem_addr, exp_m1_first ? 32'h20 : 32'h10);
    step(); step();
    check("arb_done", {m0_done, m1_done}, exp_m1_first ? 2'b01 : 2'b10);
    m0_req = 0; m1_req = 0; mem_arready = 0; mem_rvalid = 0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
